// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending-machine controller: the controller
// state encoding, the coin-slot encodings and the rupee value of each coin.
// ---------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    // Coin slot encodings; 2'b11 is the invalid/unrecognised coin.
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam logic [6:0] COIN_5_VAL  = 7'd5;
    localparam logic [6:0] COIN_10_VAL = 7'd10;

    // Value of a coin event in rupees; zero for "no coin" and for the
    // invalid encoding, so a zero result also means "not acceptable".
    function automatic logic [6:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_5:  coin_value = COIN_5_VAL;
            COIN_10: coin_value = COIN_10_VAL;
            default: coin_value = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// ---------------------------------------------------------------------------
// vend_idle_timer
// Counts idle cycles while the controller holds credit.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   clear   - restart the count from zero (has priority over enable)
//   enable  - count this cycle
//   expired - high during the TIMEOUT-th consecutive enabled idle cycle
// ---------------------------------------------------------------------------
module vend_idle_timer #(
    parameter int TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The counter parks at LAST; the controller leaves CREDIT on expiry,
    // which clears it, so it never needs to wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/vend_controller.sv
// ---------------------------------------------------------------------------
// vend_controller
// Coin-operated vending controller: accumulates 5/10 rupee coins, sells one
// of four products, then pays back the remaining credit one coin at a time.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in[1:0]           - coin event (00 none, 01 5rs, 10 10rs, 11 invalid)
//   sel_valid, sel_id - product selection strobe and product number
//   cancel            - refund request
//   disp_req, disp_id - dispense request / product, held until disp_ack
//   chg_req, chg_coin - hopper request / coin (0: 5rs, 1: 10rs), until chg_ack
//   coin_rej          - pulse: the coin offered last cycle was returned
//   err               - pulse: selection with insufficient credit
//   credit[5:0]       - current credit in rupees
// All outputs are registered.
// ---------------------------------------------------------------------------
module vend_controller #(
    parameter int PRICE0     = 15,
    parameter int PRICE1     = 20,
    parameter int PRICE2     = 25,
    parameter int PRICE3     = 30,
    parameter int MAX_CREDIT = 50,
    parameter int TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    input  logic       cancel,
    output logic       disp_req,
    output logic [1:0] disp_id,
    input  logic       disp_ack,
    output logic       chg_req,
    output logic       chg_coin,
    input  logic       chg_ack,
    output logic       coin_rej,
    output logic       err,
    output logic [5:0] credit
);

    import vend_pkg::*;

    localparam logic [6:0] MAX_C = 7'(MAX_CREDIT);

    function automatic logic [5:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    price_of = 6'(PRICE0);
            2'd1:    price_of = 6'(PRICE1);
            2'd2:    price_of = 6'(PRICE2);
            default: price_of = 6'(PRICE3);
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [5:0] credit_q, credit_d;
    logic       disp_req_q, disp_req_d;
    logic [1:0] disp_id_q, disp_id_d;
    logic       chg_req_q, chg_req_d;
    logic       chg_coin_q, chg_coin_d;
    logic       coin_rej_q, coin_rej_d;
    logic       err_q, err_d;

    logic       coin_accept;
    logic       tmr_clear, tmr_expired;

    // Coin and selection qualifiers evaluated against the current credit.
    logic       coin_present;
    logic [6:0] coin_sum;
    logic       coin_fits;
    logic [5:0] price;
    logic       sel_ok;

    assign coin_present = (in != COIN_NONE);
    assign coin_sum     = {1'b0, credit_q} + coin_value(in);
    assign coin_fits    = (coin_value(in) != 7'd0) && (coin_sum <= MAX_C);
    assign price        = price_of(sel_id);
    assign sel_ok       = (credit_q >= price);

    // Any accepted coin or selection attempt counts as activity.
    assign tmr_clear = (state_q != CREDIT) || coin_accept || sel_valid;

    vend_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (state_q == CREDIT),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        disp_req_d  = disp_req_q;
        disp_id_d   = disp_id_q;
        chg_req_d   = chg_req_q;
        chg_coin_d  = chg_coin_q;
        coin_rej_d  = 1'b0;
        err_d       = 1'b0;
        coin_accept = 1'b0;

        case (state_q)
            IDLE: begin
                // Cancel has nothing to refund here but still outranks a coin.
                if (!cancel && coin_fits) begin
                    credit_d    = coin_sum[5:0];
                    coin_accept = 1'b1;
                    state_d     = CREDIT;
                end else begin
                    coin_rej_d = coin_present;
                end
            end

            CREDIT: begin
                if (cancel) begin
                    coin_rej_d = coin_present;
                    chg_req_d  = 1'b1;
                    chg_coin_d = (credit_q >= 6'd10);
                    state_d    = CHANGE;
                end else if (sel_valid && sel_ok) begin
                    coin_rej_d = coin_present;
                    credit_d   = credit_q - price;
                    disp_req_d = 1'b1;
                    disp_id_d  = sel_id;
                    state_d    = DISPENSE;
                end else begin
                    // A failed selection does not block a coin on the same cycle.
                    err_d = sel_valid;
                    if (coin_fits) begin
                        credit_d    = coin_sum[5:0];
                        coin_accept = 1'b1;
                    end else begin
                        coin_rej_d = coin_present;
                    end
                    if (!sel_valid && !coin_fits && tmr_expired) begin
                        chg_req_d  = 1'b1;
                        chg_coin_d = (credit_q >= 6'd10);
                        state_d    = CHANGE;
                    end
                end
            end

            DISPENSE: begin
                coin_rej_d = coin_present;
                if (disp_ack) begin
                    disp_req_d = 1'b0;
                    disp_id_d  = 2'd0;
                    if (credit_q != 6'd0) begin
                        chg_req_d  = 1'b1;
                        chg_coin_d = (credit_q >= 6'd10);
                        state_d    = CHANGE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            CHANGE: begin
                coin_rej_d = coin_present;
                if (chg_ack) begin
                    // chg_coin is only 1 when credit >= 10, so this cannot underflow.
                    credit_d = credit_q - (chg_coin_q ? 6'd10 : 6'd5);
                    if (credit_d == 6'd0) begin
                        chg_req_d  = 1'b0;
                        chg_coin_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        chg_coin_d = (credit_d >= 6'd10);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            credit_q   <= 6'd0;
            disp_req_q <= 1'b0;
            disp_id_q  <= 2'd0;
            chg_req_q  <= 1'b0;
            chg_coin_q <= 1'b0;
            coin_rej_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            disp_req_q <= disp_req_d;
            disp_id_q  <= disp_id_d;
            chg_req_q  <= chg_req_d;
            chg_coin_q <= chg_coin_d;
            coin_rej_q <= coin_rej_d;
            err_q      <= err_d;
        end
    end

    assign disp_req = disp_req_q;
    assign disp_id  = disp_id_q;
    assign chg_req  = chg_req_q;
    assign chg_coin = chg_coin_q;
    assign coin_rej = coin_rej_q;
    assign err      = err_q;
    assign credit   = credit_q;

endmodule

// File: tb/tb_vend_controller.sv
// ---------------------------------------------------------------------------
// tb_vend_controller
// Randomised and directed stimulus for vend_controller, checked every cycle
// against a transaction-level model of the vending rules.
// ---------------------------------------------------------------------------
module tb_vend_controller;

    localparam int MAX_CREDIT = 50;
    localparam int TIMEOUT    = 200;

    // Model modes (the model's own bookkeeping, not the DUT encoding).
    localparam int M_IDLE = 0, M_CREDIT = 1, M_DISP = 2, M_CHANGE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic       disp_req, chg_req, chg_coin, coin_rej, err;
    logic [1:0] disp_id;
    logic [5:0] credit;

    int vectors = 0;
    int miscompares = 0;
    bit run_cmp = 1'b0;

    int prices[4] = '{15, 20, 25, 30};
    int m_mode = M_IDLE;
    int m_credit = 0;
    int m_idle = 0;
    int m_id = 0;
    int m_rej = 0;
    int m_err = 0;

    vend_controller dut (
        .clk       (clk),
        .rst       (rst),
        .in        (coin),
        .sel_valid (sel_valid),
        .sel_id    (sel_id),
        .cancel    (cancel),
        .disp_req  (disp_req),
        .disp_id   (disp_id),
        .disp_ack  (disp_ack),
        .chg_req   (chg_req),
        .chg_coin  (chg_coin),
        .chg_ack   (chg_ack),
        .coin_rej  (coin_rej),
        .err       (err),
        .credit    (credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies the vending rules to the inputs seen at each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_id = 0; m_rej = 0; m_err = 0;
        end else begin
            int cv;
            bit present, ok;
            cv = (coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0;
            present = (coin != 2'b00);
            ok = (cv != 0) && (m_credit + cv <= MAX_CREDIT);
            m_rej = 0;
            m_err = 0;
            case (m_mode)
                M_IDLE: begin
                    if (!cancel && ok) begin
                        m_credit += cv; m_mode = M_CREDIT; m_idle = 0;
                    end else m_rej = present;
                end
                M_CREDIT: begin
                    if (cancel) begin
                        m_rej = present; m_mode = M_CHANGE;
                    end else if (sel_valid && m_credit >= prices[sel_id]) begin
                        m_rej = present; m_credit -= prices[sel_id]; m_id = sel_id; m_mode = M_DISP;
                    end else begin
                        m_err = sel_valid;
                        if (ok) m_credit += cv; else m_rej = present;
                        if (sel_valid || ok) m_idle = 0;
                        else begin
                            m_idle++;
                            if (m_idle >= TIMEOUT) m_mode = M_CHANGE;
                        end
                    end
                end
                M_DISP: begin
                    m_rej = present;
                    if (disp_ack) m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
                end
                default: begin
                    m_rej = present;
                    if (chg_ack) begin
                        m_credit -= (m_credit >= 10) ? 10 : 5;
                        if (m_credit == 0) m_mode = M_IDLE;
                    end
                end
            endcase
        end
    end

    // Compare process: every cycle outside reset, all outputs vs the model.
    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("credit", credit, m_credit);
            chk("disp_req", disp_req, m_mode == M_DISP);
            chk("disp_id", disp_id, (m_mode == M_DISP) ? m_id : 0);
            chk("chg_req", chg_req, m_mode == M_CHANGE);
            chk("chg_coin", chg_coin, (m_mode == M_CHANGE) && (m_credit >= 10));
            chk("coin_rej", coin_rej, m_rej);
            chk("err", err, m_err);
        end
    end

    // Apply one cycle of inputs; returns at the following falling edge.
    task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] sid,
                       input logic cn, input logic da, input logic ca);
        coin = c; sel_valid = sv; sel_id = sid; cancel = cn; disp_ack = da; chg_ack = ca;
        @(negedge clk);
        coin = 2'b00; sel_valid = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_cmp = 1'b1;
        @(negedge clk);
        // Reset state.
        chk("rst_credit", credit, 0);
        chk("rst_disp_req", disp_req, 0);
        chk("rst_chg_req", chg_req, 0);
        chk("rst_err", err, 0);

        // Two 10rs coins, buy product 0, one 5rs change coin.
        cyc(2'b10, 0, 0, 0, 0, 0);
        cyc(2'b10, 0, 0, 0, 0, 0);
        chk("buy_credit20", credit, 20);
        cyc(2'b00, 1, 2'd0, 0, 0, 0);
        chk("buy_disp_req", disp_req, 1);
        chk("buy_disp_id", disp_id, 0);
        chk("buy_credit5", credit, 5);
        idle_n(2);
        chk("buy_disp_hold", disp_req, 1);
        cyc(2'b00, 0, 0, 0, 1, 0);
        chk("buy_disp_drop", disp_req, 0);
        chk("buy_chg_req", chg_req, 1);
        chk("buy_chg_coin", chg_coin, 0);
        cyc(2'b00, 0, 0, 0, 0, 1);
        chk("buy_chg_done", chg_req, 0);
        chk("buy_credit0", credit, 0);

        // Insufficient credit, then cancel.
        cyc(2'b01, 0, 0, 0, 0, 0);
        cyc(2'b00, 1, 2'd3, 0, 0, 0);
        chk("poor_err", err, 1);
        chk("poor_credit", credit, 5);
        idle_n(1);
        chk("poor_err_pulse", err, 0);
        cyc(2'b00, 0, 0, 1, 0, 0);
        chk("cancel_chg_req", chg_req, 1);
        chk("cancel_chg_coin", chg_coin, 0);
        cyc(2'b00, 0, 0, 0, 0, 1);
        chk("cancel_done", chg_req, 0);
        chk("cancel_credit", credit, 0);

        // Credit ceiling.
        for (int i = 0; i < 5; i++) cyc(2'b10, 0, 0, 0, 0, 0);
        chk("max_credit", credit, 50);
        cyc(2'b10, 0, 0, 0, 0, 0);
        chk("max_coin_rej", coin_rej, 1);
        chk("max_credit_kept", credit, 50);
        cyc(2'b00, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(2'b00, 0, 0, 0, 0, 1);
        chk("max_drained", credit, 0);
        chk("max_drained_req", chg_req, 0);

        // Idle timeout auto-refund.
        cyc(2'b10, 0, 0, 0, 0, 0);
        idle_n(TIMEOUT - 1);
        chk("tmo_not_yet", chg_req, 0);
        idle_n(1);
        chk("tmo_chg_req", chg_req, 1);
        chk("tmo_chg_coin", chg_coin, 1);
        cyc(2'b00, 0, 0, 0, 0, 1);
        chk("tmo_done", chg_req, 0);
        chk("tmo_credit", credit, 0);

        // Selection with a coin on the same cycle.
        cyc(2'b10, 0, 0, 0, 0, 0);
        cyc(2'b10, 0, 0, 0, 0, 0);
        cyc(2'b01, 0, 0, 0, 0, 0);
        cyc(2'b10, 1, 2'd0, 0, 0, 0);
        chk("mix_coin_rej", coin_rej, 1);
        chk("mix_credit", credit, 10);
        cyc(2'b00, 0, 0, 0, 1, 0);
        chk("mix_chg_coin", chg_coin, 1);
        cyc(2'b00, 0, 0, 0, 0, 1);
        chk("mix_done", chg_req, 0);
        chk("mix_credit0", credit, 0);

        // Asynchronous reset during a dispense.
        cyc(2'b10, 0, 0, 0, 0, 0);
        cyc(2'b10, 0, 0, 0, 0, 0);
        cyc(2'b00, 1, 2'd1, 0, 0, 0);
        chk("arst_pre_disp", disp_req, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_disp_req", disp_req, 0);
        chk("arst_disp_id", disp_id, 0);
        chk("arst_credit", credit, 0);
        chk("arst_chg_req", chg_req, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(2'b00, 0, 0, 0, 1, 1);
        chk("arst_idle_credit", credit, 0);
        chk("arst_idle_req", disp_req, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [1:0] c;
            r = $urandom_range(0, 9);
            c = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            cyc(c, $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0);
        end

        // Quiet traffic so idle timeouts occur under the model too.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 299) == 0) ? 2'b10 : 2'b00,
                $urandom_range(0, 399) == 0, 2'($urandom_range(0, 3)),
                1'b0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE0, default 15, price of product 0 in rupees.
REQ-002 SHALL have parameter PRICE1, default 20, price of product 1 in rupees.
REQ-003 SHALL have parameter PRICE2, default 25, price of product 2 in rupees.
REQ-004 SHALL have parameter PRICE3, default 30, price of product 3 in rupees.
REQ-005 SHALL have parameter MAX_CREDIT, default 50, credit ceiling in rupees.
REQ-006 SHALL have parameter TIMEOUT, default 200, idle cycles in CREDIT before auto-refund.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port in, input, 2 bits, coin event: 00 none, 01 5rs, 10 10rs, 11 invalid.
REQ-010 SHALL have port sel_valid, input, 1 bit, one-cycle product selection strobe.
REQ-011 SHALL have port sel_id, input, 2 bits, selected product; sampled with sel_valid.
REQ-012 SHALL have port cancel, input, 1 bit, one-cycle refund request.
REQ-013 SHALL have port disp_req, output, 1 bit, dispense request to the motor.
REQ-014 SHALL have port disp_id, output, 2 bits, product being dispensed.
REQ-015 SHALL have port disp_ack, input, 1 bit, dispenser completion.
REQ-016 SHALL have port chg_req, output, 1 bit, change-hopper request.
REQ-017 SHALL have port chg_coin, output, 1 bit, hopper coin select: 0 is 5rs, 1 is 10rs.
REQ-018 SHALL have port chg_ack, input, 1 bit, hopper ejected one coin.
REQ-019 SHALL have port coin_rej, output, 1 bit, one-cycle pulse when the coin presented that cycle is returned.
REQ-020 SHALL have port err, output, 1 bit, one-cycle pulse on a selection with insufficient credit.
REQ-021 SHALL have port credit, output, 6 bits, current credit in rupees.

Function
REQ-022 SHALL use FSM states IDLE, CREDIT, DISPENSE, CHANGE; all outputs registered.
REQ-023 SHALL, in IDLE or CREDIT, accept coin 01/10 by adding 5/10 to credit next cycle, and go to CREDIT.
REQ-024 SHALL pulse coin_rej and leave credit unchanged for a coin that would exceed MAX_CREDIT, for in=11, or for any coin arriving in DISPENSE or CHANGE.
REQ-025 SHALL, in CREDIT with sel_valid and credit >= PRICEn, subtract PRICEn, drive disp_id=sel_id, and assert disp_req in DISPENSE.
REQ-026 SHALL, in CREDIT with sel_valid and credit < PRICEn, pulse err, keep credit, and stay in CREDIT.
REQ-027 SHALL ignore sel_valid in IDLE; err SHALL stay 0.
REQ-028 SHALL give same-cycle priority cancel > accepted selection > coin; a coin coinciding with cancel or an accepted selection SHALL be rejected (coin_rej), while a coin coinciding with a failed selection SHALL be accepted.
REQ-029 SHALL, in CREDIT, go to CHANGE on cancel or when the idle timer reaches TIMEOUT; the idle timer SHALL restart on every accepted coin or sel_valid.
REQ-030 SHALL hold disp_req and disp_id stable until disp_ack; on disp_ack, drop disp_req next cycle and go to CHANGE if credit > 0, else to IDLE.
REQ-031 SHALL, in CHANGE, assert chg_req with chg_coin=1 if credit >= 10, else chg_coin=0; on chg_ack subtract 10 or 5 and re-evaluate the coin; go to IDLE when credit reaches 0.
REQ-032 SHALL ignore disp_ack and chg_ack while the matching req is low.
REQ-033 SHALL keep credit a multiple of 5, saturate nothing, and never underflow.

Reset
REQ-034 SHALL on rst set state IDLE, credit 0, timer 0, and disp_req, disp_id, chg_req, chg_coin, coin_rej, err all 0.
REQ-035 SHALL abort any dispense or change sequence on rst mid-operation, discarding the residual credit.

Structure
REQ-036 SHALL place the state enum, coin encodings (COIN_NONE, COIN_5, COIN_10) and coin values in package vend_pkg.
REQ-037 SHALL implement the idle timer as sub-module vend_idle_timer (clear, enable, expired).

Verification
REQ-038 SHALL test: coins 10,10 then sel_id=0 -> credit 20 -> disp_req/disp_id=0 and credit 5; after disp_ack, one chg_req with chg_coin=0, then IDLE and credit 0.
REQ-039 SHALL test: coin 5, then sel_id=3 -> err pulse, credit stays 5; cancel -> one 5rs change coin, then IDLE.
REQ-040 SHALL test: five 10rs coins then a sixth -> credit 50 and coin_rej on the sixth.
REQ-041 SHALL test: coin 10 then no activity for 200 cycles -> CHANGE, one 10rs coin, then IDLE.
REQ-042 SHALL test: coin 10, coin 10, coin 5, then sel_id=0 with a coin on the same cycle -> coin_rej, credit 10, then two chg_coin=0 ejections... corrected: one chg_coin=1 ejection.
REQ-043 SHALL test: rst asserted while disp_req is high -> all outputs 0 asynchronously, credit 0, state IDLE.
